// File: rtl/mmio_pkg.sv
// ---------------------------------------------------------------------------
// mmio_pkg : shared widths, slot map and FSM state for the MMIO slot fabric
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mmio_pkg;

  localparam int MMIO_SLOT_ADDR_WIDTH = 6;
  localparam int MMIO_REG_ADDR_WIDTH  = 5;
  localparam int MMIO_DATA_WIDTH      = 32;
  localparam int MMIO_NUM_SLOTS       = 64;
  localparam int MMIO_TIMEOUT_CYCLES  = 16;

  localparam logic [31:0] MMIO_ERR_PATTERN = 32'hDEAD_BEEF;

  localparam int SLOT_SYS_TIMER = 0;
  localparam int SLOT_UART      = 1;
  localparam int SLOT_LED       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mmio_state_e;

endpackage : mmio_pkg

`default_nettype wire

// File: rtl/mmio_wdog.sv
// ---------------------------------------------------------------------------
// mmio_wdog : access wait counter with timeout compare
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mmio_wdog
  import mmio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MMIO_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired = (count_q == LIMIT);

  // Saturates at the limit so a stalled enable can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : mmio_wdog

`default_nettype wire

// File: rtl/mmio_slot_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_slot_ctrl : decodes host MMIO accesses onto one-hot peripheral slots
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mmio_slot_ctrl
  import mmio_pkg::*;
#(
  parameter int                    SLOT_ADDR_WIDTH = MMIO_SLOT_ADDR_WIDTH,
  parameter int                    REG_ADDR_WIDTH  = MMIO_REG_ADDR_WIDTH,
  parameter int                    DATA_WIDTH      = MMIO_DATA_WIDTH,
  parameter int                    NUM_SLOTS       = MMIO_NUM_SLOTS,
  parameter int                    TIMEOUT_CYCLES  = MMIO_TIMEOUT_CYCLES,
  parameter logic [DATA_WIDTH-1:0] ERR_PATTERN     = DATA_WIDTH'(MMIO_ERR_PATTERN)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 mmio_cs,
  input  logic                                 mmio_wr,
  input  logic                                 mmio_rd,
  input  logic [SLOT_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] mmio_addr,
  input  logic [DATA_WIDTH-1:0]                mmio_wr_data,
  output logic [DATA_WIDTH-1:0]                mmio_rd_data,
  output logic                                 mmio_ready,
  output logic [NUM_SLOTS-1:0]                 slot_cs,
  output logic                                 slot_mem_wr,
  output logic                                 slot_mem_rd,
  output logic [REG_ADDR_WIDTH-1:0]            slot_reg_addr,
  output logic [DATA_WIDTH-1:0]                slot_wr_data,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0]      slot_rd_data,
  input  logic [NUM_SLOTS-1:0]                 slot_ready,
  input  logic                                 err_clr,
  output logic                                 err_timeout,
  output logic [SLOT_ADDR_WIDTH-1:0]           err_slot
);

  localparam int ADDR_W    = SLOT_ADDR_WIDTH + REG_ADDR_WIDTH;
  localparam int MAX_SLOTS = 1 << SLOT_ADDR_WIDTH;
  localparam logic [SLOT_ADDR_WIDTH:0] NUM_SLOTS_W = (SLOT_ADDR_WIDTH + 1)'(NUM_SLOTS);

  mmio_state_e state_q, state_d;

  logic [SLOT_ADDR_WIDTH-1:0] slot_idx_q,  slot_idx_d;
  logic                       slot_ok_q,   slot_ok_d;
  logic [NUM_SLOTS-1:0]       slot_cs_q,   slot_cs_d;
  logic                       mem_wr_q,    mem_wr_d;
  logic                       mem_rd_q,    mem_rd_d;
  logic [REG_ADDR_WIDTH-1:0]  reg_addr_q,  reg_addr_d;
  logic [DATA_WIDTH-1:0]      wr_data_q,   wr_data_d;
  logic [DATA_WIDTH-1:0]      rd_data_q,   rd_data_d;
  logic                       ready_q,     ready_d;
  logic                       err_to_q,    err_to_d;
  logic [SLOT_ADDR_WIDTH-1:0] err_slot_q,  err_slot_d;

  logic [SLOT_ADDR_WIDTH-1:0] req_slot;
  logic [REG_ADDR_WIDTH-1:0]  req_reg;
  logic                       req_valid;
  logic                       req_slot_ok;
  logic [MAX_SLOTS-1:0]       ready_pad;
  logic                       sel_ready;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic [DATA_WIDTH-1:0]      rd_arr [NUM_SLOTS];
  logic                       acc_ok;
  logic                       acc_err;
  logic                       wdog_expired;

  assign req_slot    = mmio_addr[ADDR_W-1:REG_ADDR_WIDTH];
  assign req_reg     = mmio_addr[REG_ADDR_WIDTH-1:0];
  assign req_valid   = mmio_cs & (mmio_rd | mmio_wr);
  assign req_slot_ok = ({1'b0, req_slot} < NUM_SLOTS_W);

  // Ready is padded to the full slot-index space so an unpopulated index reads 0.
  assign ready_pad = MAX_SLOTS'(slot_ready);
  assign sel_ready = slot_ok_q & ready_pad[slot_idx_q];

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_rd_unpack
    assign rd_arr[gi] = slot_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_idx_q == SLOT_ADDR_WIDTH'(i)) begin
        sel_data = rd_arr[i];
      end
    end
  end

  // Ready is tested before expiry so a response on the last counted cycle wins.
  assign acc_ok  = (state_q == ST_ACCESS) & sel_ready;
  assign acc_err = (state_q == ST_ACCESS) & ~sel_ready & (~slot_ok_q | wdog_expired);

  mmio_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  ((state_q == ST_IDLE) & req_valid),
    .enable (state_q == ST_ACCESS),
    .expired(wdog_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req_valid)        state_d = ST_ACCESS;
      ST_ACCESS: if (acc_ok | acc_err) state_d = ST_DONE;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Slot-side strobes are only driven for populated slots, and only during ACCESS.
  always_comb begin
    slot_idx_d = slot_idx_q;
    slot_ok_d  = slot_ok_q;
    slot_cs_d  = '0;
    mem_wr_d   = 1'b0;
    mem_rd_d   = 1'b0;
    reg_addr_d = '0;
    wr_data_d  = '0;
    rd_data_d  = rd_data_q;
    ready_d    = 1'b0;
    err_to_d   = err_to_q;
    err_slot_d = err_slot_q;
    if (err_clr) begin
      err_to_d   = 1'b0;
      err_slot_d = '0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          slot_idx_d = req_slot;
          slot_ok_d  = req_slot_ok;
          if (req_slot_ok) begin
            slot_cs_d  = NUM_SLOTS'(1) << req_slot;
            mem_wr_d   = mmio_wr;
            mem_rd_d   = mmio_rd & ~mmio_wr;
            reg_addr_d = req_reg;
            wr_data_d  = mmio_wr_data;
          end
        end
      end
      ST_ACCESS: begin
        if (acc_ok) begin
          ready_d = 1'b1;
          if (mem_rd_q) rd_data_d = sel_data;
        end else if (acc_err) begin
          ready_d    = 1'b1;
          rd_data_d  = ERR_PATTERN;
          err_to_d   = 1'b1;
          err_slot_d = slot_idx_q;
        end else begin
          slot_cs_d  = slot_cs_q;
          mem_wr_d   = mem_wr_q;
          mem_rd_d   = mem_rd_q;
          reg_addr_d = reg_addr_q;
          wr_data_d  = wr_data_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_idx_q <= '0;
      slot_ok_q  <= 1'b0;
      slot_cs_q  <= '0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      ready_q    <= 1'b0;
      err_to_q   <= 1'b0;
      err_slot_q <= '0;
    end else begin
      slot_idx_q <= slot_idx_d;
      slot_ok_q  <= slot_ok_d;
      slot_cs_q  <= slot_cs_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      ready_q    <= ready_d;
      err_to_q   <= err_to_d;
      err_slot_q <= err_slot_d;
    end
  end

  assign slot_cs       = slot_cs_q;
  assign slot_mem_wr   = mem_wr_q;
  assign slot_mem_rd   = mem_rd_q;
  assign slot_reg_addr = reg_addr_q;
  assign slot_wr_data  = wr_data_q;
  assign mmio_rd_data  = rd_data_q;
  assign mmio_ready    = ready_q;
  assign err_timeout   = err_to_q;
  assign err_slot      = err_slot_q;

endmodule : mmio_slot_ctrl

`default_nettype wire

// File: tb/tb_mmio_slot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmio_slot_ctrl : scoreboard bench for mmio_slot_ctrl with an 8-slot map
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mmio_slot_ctrl;
  import mmio_pkg::*;

  localparam int SAW = 6;
  localparam int RAW = 5;
  localparam int DW  = 32;
  localparam int NS  = 8;
  localparam int TO  = 16;
  localparam int NEVER = 1000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              mmio_cs, mmio_wr, mmio_rd;
  logic [SAW+RAW-1:0] mmio_addr;
  logic [DW-1:0]     mmio_wr_data;
  logic [DW-1:0]     mmio_rd_data;
  logic              mmio_ready;
  logic [NS-1:0]     slot_cs;
  logic              slot_mem_wr, slot_mem_rd;
  logic [RAW-1:0]    slot_reg_addr;
  logic [DW-1:0]     slot_wr_data;
  logic [NS*DW-1:0]  slot_rd_data;
  logic [NS-1:0]     slot_ready;
  logic              err_clr;
  logic              err_timeout;
  logic [SAW-1:0]    err_slot;

  mmio_slot_ctrl #(
    .SLOT_ADDR_WIDTH(SAW), .REG_ADDR_WIDTH(RAW), .DATA_WIDTH(DW),
    .NUM_SLOTS(NS), .TIMEOUT_CYCLES(TO), .ERR_PATTERN(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .mmio_ready(mmio_ready),
    .slot_cs(slot_cs), .slot_mem_wr(slot_mem_wr), .slot_mem_rd(slot_mem_rd),
    .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
    .slot_rd_data(slot_rd_data), .slot_ready(slot_ready),
    .err_clr(err_clr), .err_timeout(err_timeout), .err_slot(err_slot)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int clr_at   = -1;
  int cur_dly  = NEVER;
  int acc_cnt  = 0;
  logic [DW-1:0] slot_data [NS];

  typedef struct {
    string      name;
    logic [31:0] data;
    logic       err;
    logic [5:0] eslot;
    int         lat;
    logic [7:0] cs;
    int         cs_cyc;
    int         wr_cyc;
    int         rd_cyc;
    logic [4:0] reg_a;
    logic [31:0] wd;
    int         req_cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    err_clr = (cyc == clr_at);
  end

  // Slot model: the addressed slot answers after cur_dly wait cycles of ACCESS.
  always @(posedge clk) acc_cnt <= (slot_cs != '0) ? acc_cnt + 1 : 0;

  always_comb begin
    slot_ready = '0;
    if (acc_cnt == cur_dly) slot_ready = slot_cs;
  end

  always_comb begin
    slot_rd_data = '0;
    for (int i = 0; i < NS; i++) slot_rd_data[i*DW +: DW] = slot_data[i];
  end

  int         m_cs_cyc = 0, m_wr_cyc = 0, m_rd_cyc = 0;
  logic [7:0] m_cs = '0;
  logic [4:0] m_reg = '0;
  logic [31:0] m_wd = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_cs_cyc = 0; m_wr_cyc = 0; m_rd_cyc = 0;
      m_cs = '0; m_reg = '0; m_wd = '0;
    end else begin
      if (slot_cs != '0) begin m_cs_cyc++; m_cs = slot_cs; end
      if (slot_mem_wr) begin m_wr_cyc++; m_reg = slot_reg_addr; m_wd = slot_wr_data; end
      if (slot_mem_rd) begin m_rd_cyc++; m_reg = slot_reg_addr; end
      if (mmio_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_ready", 64'(mmio_ready), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, "_data"},    64'(mmio_rd_data), 64'(e.data));
          check({e.name, "_err"},     64'(err_timeout),  64'(e.err));
          check({e.name, "_errslot"}, 64'(err_slot),     64'(e.eslot));
          check({e.name, "_latency"}, 64'(cyc - e.req_cyc), 64'(e.lat));
          check({e.name, "_cs"},      64'(m_cs),         64'(e.cs));
          check({e.name, "_cs_cyc"},  64'(m_cs_cyc),     64'(e.cs_cyc));
          check({e.name, "_wr_cyc"},  64'(m_wr_cyc),     64'(e.wr_cyc));
          check({e.name, "_rd_cyc"},  64'(m_rd_cyc),     64'(e.rd_cyc));
          check({e.name, "_reg"},     64'(m_reg),        64'(e.reg_a));
          check({e.name, "_wdata"},   64'(m_wd),         64'(e.wd));
          m_cs_cyc = 0; m_wr_cyc = 0; m_rd_cyc = 0;
          m_cs = '0; m_reg = '0; m_wd = '0;
          n_done++;
        end
      end
    end
  end

  // Drives one request and pushes what the completion must look like.
  task automatic drive_req(input string name, input logic wr, input logic rd,
                           input int slot, input int reg_a, input logic [31:0] wd,
                           input int dly, input logic [31:0] exp_data,
                           input logic exp_err, input int exp_eslot,
                           input int lat, input int clr_off);
    exp_t e;
    int   n_acc;
    bit   ok;
    @(posedge clk); #1;
    ok    = (slot < NS);
    n_acc = lat - 1;
    cur_dly   = dly;
    e.name    = name;
    e.data    = exp_data;
    e.err     = exp_err;
    e.eslot   = 6'(exp_eslot);
    e.lat     = lat;
    e.cs      = ok ? (8'd1 << slot) : 8'd0;
    e.cs_cyc  = ok ? n_acc : 0;
    e.wr_cyc  = (ok && wr) ? n_acc : 0;
    e.rd_cyc  = (ok && rd && !wr) ? n_acc : 0;
    e.reg_a   = ok ? 5'(reg_a) : 5'd0;
    e.wd      = (ok && wr) ? wd : 32'd0;
    e.req_cyc = cyc;
    if (clr_off > 0) clr_at = cyc + clr_off;
    sb_q.push_back(e);
    mmio_cs = 1'b1; mmio_wr = wr; mmio_rd = rd;
    mmio_addr = {6'(slot), 5'(reg_a)}; mmio_wr_data = wd;
    @(posedge clk); #1;
    mmio_cs = 1'b0; mmio_wr = 1'b0; mmio_rd = 1'b0;
    mmio_wr_data = 32'hFFFF_FFFF;
  endtask

  task automatic wait_done(input string name, input int target, input logic [31:0] exp_data);
    bit seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk); #1;
      if (n_done >= target) seen = 1;
    end
    if (!seen) begin
      check({name, "_no_completion"}, 64'd0, 64'd1);
      sb_q.delete();
    end else begin
      @(negedge clk); #1;
      check({name, "_ready_one_cycle"}, 64'(mmio_ready), 64'd0);
      check({name, "_data_held"},       64'(mmio_rd_data), 64'(exp_data));
    end
  endtask

  task automatic do_req(input string name, input logic wr, input logic rd,
                        input int slot, input int reg_a, input logic [31:0] wd,
                        input int dly, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_eslot,
                        input int lat, input int clr_off);
    int target = n_done + 1;
    drive_req(name, wr, rd, slot, reg_a, wd, dly, exp_data, exp_err, exp_eslot, lat, clr_off);
    wait_done(name, target, exp_data);
  endtask

  task automatic pulse_clr(input string name);
    @(posedge clk); #1;
    clr_at = cyc + 1;
    repeat (2) @(posedge clk);
    #1;
    check({name, "_clr_err"},  64'(err_timeout), 64'd0);
    check({name, "_clr_slot"}, 64'(err_slot),    64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NS; i++) slot_data[i] = 32'h1000_0000 + i;
    reset_n = 1'b0;
    mmio_cs = 1'b0; mmio_wr = 1'b0; mmio_rd = 1'b0;
    mmio_addr = '0; mmio_wr_data = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   64'(mmio_ready),    64'd0);
    check("rst_rd_data", 64'(mmio_rd_data),  64'd0);
    check("rst_cs",      64'(slot_cs),       64'd0);
    check("rst_wr",      64'(slot_mem_wr),   64'd0);
    check("rst_rd",      64'(slot_mem_rd),   64'd0);
    check("rst_reg",     64'(slot_reg_addr), 64'd0);
    check("rst_err",     64'(err_timeout),   64'd0);
    check("rst_errslot", 64'(err_slot),      64'd0);
    reset_n = 1'b1;

    slot_data[SLOT_LED] = 32'h0000_00A5;
    do_req("rd_led", 1'b0, 1'b1, SLOT_LED, 3, 32'h0, 0,
           32'h0000_00A5, 1'b0, 0, 2, 0);
    do_req("wr_uart", 1'b1, 1'b0, SLOT_UART, 0, 32'h1234_5678, 4,
           32'h0000_00A5, 1'b0, 0, 6, 0);
    do_req("rd_timeout", 1'b0, 1'b1, 5, 7, 32'h0, NEVER,
           32'hDEAD_BEEF, 1'b1, 5, TO + 1, 0);
    pulse_clr("rd_timeout");
    do_req("rd_badslot", 1'b0, 1'b1, 12, 1, 32'h0, 0,
           32'hDEAD_BEEF, 1'b1, 12, 2, 0);
    pulse_clr("rd_badslot");
    do_req("rdwr_is_wr", 1'b1, 1'b1, 3, 9, 32'hCAFE_F00D, 1,
           32'hDEAD_BEEF, 1'b0, 0, 3, 0);
    slot_data[4] = 32'h0000_55AA;
    do_req("ready_at_limit", 1'b0, 1'b1, 4, 31, 32'h0, TO - 1,
           32'h0000_55AA, 1'b0, 0, TO + 1, 0);
    do_req("clr_vs_timeout", 1'b0, 1'b1, 6, 2, 32'h0, NEVER,
           32'hDEAD_BEEF, 1'b1, 6, TO + 1, TO);

    // Abort a slot-7 read two cycles into ACCESS with an asynchronous reset.
    @(posedge clk); #1;
    cur_dly = NEVER;
    mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_addr = {6'd7, 5'd4};
    @(posedge clk); #1;
    mmio_cs = 1'b0; mmio_rd = 1'b0;
    @(posedge clk); #2;
    check("abort_cs_before", 64'(slot_cs), 64'h80);
    reset_n = 1'b0;
    #1;
    check("abort_cs",      64'(slot_cs),      64'd0);
    check("abort_rd",      64'(slot_mem_rd),  64'd0);
    check("abort_ready",   64'(mmio_ready),   64'd0);
    check("abort_rd_data", 64'(mmio_rd_data), 64'd0);
    check("abort_err",     64'(err_timeout),  64'd0);
    check("abort_errslot", 64'(err_slot),     64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (TO + 4) @(posedge clk);
    #1;
    check("abort_no_err", 64'(err_timeout), 64'd0);
    slot_data[SLOT_LED] = 32'h00C0_FFEE;
    do_req("after_reset", 1'b0, 1'b1, SLOT_LED, 5, 32'h0, 2,
           32'h00C0_FFEE, 1'b0, 0, 4, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mmio_slot_ctrl

`default_nettype wire

// File: doc/mmio_slot_ctrl.md
MMIO_SLOT_CTRL -- requirements
Module: mmio_slot_ctrl

Interface
REQ-001 SHALL have parameter SLOT_ADDR_WIDTH, default 6, slot-index field width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, per-slot register field width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-004 SHALL have parameter NUM_SLOTS, default 64, populated slots, 1..2**SLOT_ADDR_WIDTH.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16, max wait for slot_ready, >=2.
REQ-006 SHALL have parameter ERR_PATTERN, default 32'hDEAD_BEEF, read data on error.
REQ-007 SHALL have port clk  in  1  single system clock; reset is asynchronous and active-low.
REQ-008 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-009 SHALL have port mmio_cs  in  1  request strobe; mmio_wr / mmio_rd  in  1 each  access type.
REQ-010 SHALL have port mmio_addr  in  SLOT_ADDR_WIDTH+REG_ADDR_WIDTH  {slot, reg}.
REQ-011 SHALL have ports mmio_wr_data  in  DATA_WIDTH; mmio_rd_data  out  DATA_WIDTH; mmio_ready  out  1 (completion pulse).
REQ-012 SHALL have ports slot_cs  out  NUM_SLOTS (one-hot), slot_mem_wr / slot_mem_rd  out  1 each, slot_reg_addr  out  REG_ADDR_WIDTH, slot_wr_data  out  DATA_WIDTH.
REQ-013 SHALL have ports slot_rd_data  in  NUM_SLOTS x DATA_WIDTH, slot_ready  in  NUM_SLOTS.
REQ-014 SHALL have ports err_clr  in  1; err_timeout  out  1 (sticky); err_slot  out  SLOT_ADDR_WIDTH.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-016 In IDLE, mmio_cs & (mmio_rd | mmio_wr) SHALL latch slot, reg, type, wr_data and enter ACCESS next cycle.
REQ-017 mmio_rd & mmio_wr both high SHALL be treated as a write.
REQ-018 In ACCESS, slot_cs[latched slot], slot_mem_wr/rd, slot_reg_addr, slot_wr_data SHALL be held stable; all outputs are registered and zero outside ACCESS.
REQ-019 The wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle.
REQ-020 slot_ready[latched slot] high in ACCESS SHALL capture slot_rd_data[slot] (reads only) and enter DONE.
REQ-021 Counter reaching TIMEOUT_CYCLES-1 without ready SHALL load ERR_PATTERN, set err_timeout, load err_slot, enter DONE.
REQ-022 Ready on the final counted cycle SHALL win over timeout.
REQ-023 Slot index >= NUM_SLOTS SHALL assert no slot_cs, skip wait, enter DONE with ERR_PATTERN and error set.
REQ-024 DONE SHALL last exactly one cycle with mmio_ready=1; mmio_rd_data valid then, held until next completion; return to IDLE.
REQ-025 Minimum latency: request cycle N -> mmio_ready cycle N+2; a write yields mmio_rd_data unchanged.
REQ-026 Requests arriving in ACCESS or DONE SHALL be ignored (host waits for mmio_ready).
REQ-027 err_clr SHALL clear err_timeout and err_slot; a new error in the same cycle SHALL win.

Reset
REQ-028 reset_n low SHALL asynchronously force IDLE, counter 0, slot_cs 0, strobes 0, mmio_ready 0, mmio_rd_data 0, err_timeout 0, err_slot 0.
REQ-029 Reset mid-ACCESS SHALL abort the access with no mmio_ready and no error flag.
REQ-030 Reset release SHALL be synchronised externally; the block adds no release logic.

Structure
REQ-031 Shared package mmio_pkg SHALL hold default widths, NUM_SLOTS, FSM state typedef, ERR_PATTERN, slot-number constants (system timer 0, UART 1, LED 2).
REQ-032 Wait counter and timeout compare SHALL be sub-module mmio_wdog (clear, enable, expired).

Verification
REQ-033 Read slot 2 reg 3, slot_ready high immediately, data 32'h0000_00A5 -> mmio_ready at N+2, mmio_rd_data=32'h0000_00A5, slot_cs=1<<2 during ACCESS only.
REQ-034 Write slot 1 reg 0 data 32'h1234_5678, ready after 4 wait cycles -> strobes held 5 cycles, mmio_ready at N+6, no error.
REQ-035 Read slot 5, never ready -> mmio_ready at N+1+TIMEOUT_CYCLES, data 32'hDEAD_BEEF, err_timeout=1, err_slot=5.
REQ-036 NUM_SLOTS=8, read slot 12 -> no slot_cs, mmio_ready at N+2, ERR_PATTERN, err_slot=12; err_clr -> flags 0.
REQ-037 reset_n low during ACCESS -> all outputs 0 asynchronously; next request completes normally.
REQ-038 Ready on timeout-limit cycle, plus err_clr coincident with new timeout -> data captured, no error; error remains set respectively.
